// File: rtl/hera_regf_mp_if.sv
// Register-file port bundle: read ports, ALU write, deferred load, aux, call/return window, status.
// The master modport drives requests; the slave modport (the register file) returns data and status.
interface hera_regf_mp_if #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   parameter int NRD    = 2
);
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic                  wr_en;
   logic [AW-1:0]         wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic                  ld_en;
   logic [AW-1:0]         ld_addr;
   logic [DATA_W-1:0]     ld_data;
   logic                  aux_en;
   logic [DATA_W-1:0]     aux_data;
   logic                  call_en;
   logic [DATA_W-1:0]     call_ofs;
   logic                  ret_en;
   logic [DATA_W-1:0]     ret_data;
   logic [2:0]            ld_flags;
   logic                  stall;
   logic                  err;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, ld_en, ld_addr, ld_data,
             aux_en, aux_data, call_en, call_ofs, ret_en, ret_data,
      input  rd_data, ld_flags, stall, err
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, ld_en, ld_addr, ld_data,
             aux_en, aux_data, call_en, call_ofs, ret_en, ret_data,
      output rd_data, ld_flags, stall, err
   );
endinterface

// File: rtl/hera_regf_mp.sv
// Multi-port register file with deferred load, call/return window on the top three registers; HERA_REGF_BYPASS_EN forwards ld_data.
// Reads are combinational, writes land on the next clk edge; a read of a pending load target raises stall (no stall with bypass).
module hera_regf_mp #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16,
   parameter int NRD    = 2
) (
   input  logic           clk,
   input  logic           rst,
   hera_regf_mp_if.slave  bus
);
   localparam int AW  = $clog2(NREG);
   localparam int WLO = NREG - 3;
   localparam int WMD = NREG - 2;
   localparam int WHI = NREG - 1;

   logic [DATA_W-1:0] regs     [NREG];
   logic [DATA_W-1:0] regs_nxt [NREG];
   logic              pending;
   logic [AW-1:0]     ld_addr_q;
   logic              err_q;

   logic              shift;
   logic              ld_ok;
   logic [DATA_W-1:0] sh_lo, sh_md, sh_hi;
   logic [AW-1:0]     ra;
   logic [DATA_W-1:0] rd;
   logic              stall_c;

   assign shift = bus.call_en ^ bus.ret_en;
   assign ld_ok = bus.ld_en && (bus.ld_addr != '0);

   // Priority, lowest first: completing load, ALU write, aux; a window shift replaces all but the load.
   always_comb begin
      regs_nxt = regs;
      for (int i = 1; i < NREG; i++) begin
         if (pending && ld_addr_q == AW'(i))
            regs_nxt[i] = bus.ld_data;
         if (bus.wr_en && bus.wr_addr == AW'(i))
            regs_nxt[i] = bus.wr_data;
      end
      if (bus.aux_en)
         regs_nxt[WLO] = bus.aux_data;

      if (bus.call_en) begin
         sh_lo = regs[WMD];
         sh_md = regs[WHI];
         sh_hi = regs[WHI] + bus.call_ofs;
      end else begin
         sh_lo = bus.ret_data;
         sh_md = regs[WLO];
         sh_hi = regs[WMD];
      end

      if (shift) begin
         regs_nxt[WLO] = (pending && ld_addr_q == AW'(WLO)) ? bus.ld_data : sh_lo;
         regs_nxt[WMD] = (pending && ld_addr_q == AW'(WMD)) ? bus.ld_data : sh_md;
         regs_nxt[WHI] = (pending && ld_addr_q == AW'(WHI)) ? bus.ld_data : sh_hi;
      end
      regs_nxt[0] = '0;
   end

   always_comb begin
      bus.rd_data = '0;
      stall_c     = 1'b0;
      ra          = '0;
      rd          = '0;
      for (int k = 0; k < NRD; k++) begin
         ra = bus.rd_addr[k*AW +: AW];
         rd = (ra == '0) ? '0 : regs[ra];
`ifdef HERA_REGF_BYPASS_EN
         if (pending && ra == ld_addr_q && ra != '0)
            rd = bus.ld_data;
`else
         if (pending && ra == ld_addr_q && ra != '0)
            stall_c = 1'b1;
`endif
         bus.rd_data[k*DATA_W +: DATA_W] = rd;
      end
   end

`ifdef HERA_REGF_BYPASS_EN
   assign bus.stall = 1'b0;
`else
   assign bus.stall = stall_c;
`endif

   assign bus.ld_flags = pending ? {1'b1, bus.ld_data[DATA_W-1], bus.ld_data == '0} : 3'b000;
   assign bus.err      = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
         pending   <= 1'b0;
         ld_addr_q <= '0;
         err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= regs_nxt[i];
         pending <= ld_ok;
         if (ld_ok)
            ld_addr_q <= bus.ld_addr;
         err_q <= (bus.call_en && bus.ret_en) || (bus.ld_en && bus.ld_addr == '0);
      end
   end
endmodule

// File: tb/tb_hera_regf_mp.sv
// Directed bench for hera_regf_mp: reference model checked every cycle plus hand-computed expectations.
module tb_hera_regf_mp;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hera_regf_mp_if #(.DATA_W(16), .NREG(16), .NRD(2)) bus ();
   hera_regf_mp_if #(.DATA_W(32), .NREG(32), .NRD(4)) bus2 ();

   hera_regf_mp #(.DATA_W(16), .NREG(16), .NRD(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
   hera_regf_mp #(.DATA_W(32), .NREG(32), .NRD(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference model of the 16x16 instance
   logic [15:0] m_r [16] = '{default: 16'h0};
   logic        m_pend  = 1'b0;
   logic [3:0]  m_paddr = 4'h0;
   logic        m_err   = 1'b0;
   logic [15:0] nx [16];
   logic [15:0] w  [3];
   logic        sh;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) m_r[i] <= 16'h0;
         m_pend  <= 1'b0;
         m_paddr <= 4'h0;
         m_err   <= 1'b0;
      end else begin
         nx = m_r;
         sh = bus.call_en != bus.ret_en;
         if (m_pend) nx[m_paddr] = bus.ld_data;
         if (bus.wr_en && !(sh && bus.wr_addr >= 4'd13)) nx[bus.wr_addr] = bus.wr_data;
         if (bus.aux_en && !sh) nx[13] = bus.aux_data;
         if (sh) begin
            if (bus.call_en) w = '{m_r[14], m_r[15], m_r[15] + bus.call_ofs};
            else             w = '{bus.ret_data, m_r[13], m_r[14]};
            for (int j = 0; j < 3; j++)
               if (!(m_pend && m_paddr == 4'(13 + j))) nx[13 + j] = w[j];
         end
         nx[0] = 16'h0;
         m_r    <= nx;
         m_pend <= bus.ld_en && bus.ld_addr != 4'h0;
         if (bus.ld_en && bus.ld_addr != 4'h0) m_paddr <= bus.ld_addr;
         m_err  <= (bus.call_en && bus.ret_en) || (bus.ld_en && bus.ld_addr == 4'h0);
      end
   end

   function automatic logic [15:0] exp_rd(input logic [3:0] a);
      if (a == 4'h0) return 16'h0;
`ifdef HERA_REGF_BYPASS_EN
      if (m_pend && a == m_paddr) return bus.ld_data;
`endif
      return m_r[a];
   endfunction

   function automatic logic exp_stall();
`ifdef HERA_REGF_BYPASS_EN
      return 1'b0;
`else
      return m_pend && (bus.rd_addr[3:0] == m_paddr || bus.rd_addr[7:4] == m_paddr);
`endif
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++)
         chk($sformatf("model_rd%0d", k), bus.rd_data[k*16 +: 16], exp_rd(bus.rd_addr[k*4 +: 4]));
      chk("model_stall", bus.stall, exp_stall());
      chk("model_flags", bus.ld_flags, m_pend ? {1'b1, bus.ld_data[15], bus.ld_data == 16'h0} : 3'b000);
      chk("model_err", bus.err, m_err);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
      bus.ld_en = 0; bus.ld_addr = 0; bus.ld_data = 0;
      bus.aux_en = 0; bus.aux_data = 0;
      bus.call_en = 0; bus.call_ofs = 0;
      bus.ret_en = 0; bus.ret_data = 0;
   endtask

   task automatic idle2();
      bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_data = 0;
      bus2.ld_en = 0; bus2.ld_addr = 0; bus2.ld_data = 0;
      bus2.aux_en = 0; bus2.aux_data = 0;
      bus2.call_en = 0; bus2.call_ofs = 0;
      bus2.ret_en = 0; bus2.ret_data = 0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      idle(); bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d;
      step(); idle();
   endtask

   task automatic wr2(input logic [4:0] a, input logic [31:0] d);
      idle2(); bus2.wr_en = 1; bus2.wr_addr = a; bus2.wr_data = d;
      step(); idle2();
   endtask

   task automatic peek(input string nm, input logic [3:0] a, input logic [15:0] e);
      bus.rd_addr[3:0] = a;
      #1;
      chk(nm, bus.rd_data[15:0], e);
   endtask

   initial begin
      idle(); idle2();
      bus.rd_addr  = {4'd14, 4'd0};
      bus2.rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd0", bus.rd_data[15:0], 16'h0);
      chk("rst_stall", bus.stall, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      rst = 1'b1;
      step();

      // Deferred load to R5 with a same-cycle read
      bus.ld_en = 1; bus.ld_addr = 5; step();
      idle(); bus.ld_data = 16'h8000; bus.rd_addr[3:0] = 4'd5; #1;
      chk("ld_flags_pend", bus.ld_flags, 3'b110);
`ifdef HERA_REGF_BYPASS_EN
      chk("bypass_rd", bus.rd_data[15:0], 16'h8000);
      chk("bypass_stall", bus.stall, 1'b0);
`else
      chk("hazard_stall", bus.stall, 1'b1);
      chk("stale_rd", bus.rd_data[15:0], 16'h0);
`endif
      step(); idle();
      peek("r5_loaded", 4'd5, 16'h8000);
      chk("ld_flags_idle", bus.ld_flags, 3'b000);

      // Back-to-back loads, write to another register alongside
      wr(4'd7, 16'h7777);
      bus.ld_en = 1; bus.ld_addr = 6; step();
      bus.ld_addr = 7; bus.ld_data = 16'h0066;
      bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 16'h2222; #1;
      chk("b2b_flags", bus.ld_flags, 3'b100);
      step(); idle(); #1;
      chk("zero_flags", bus.ld_flags, 3'b101);
      step();
      peek("r6_b2b", 4'd6, 16'h0066);
      peek("r7_b2b", 4'd7, 16'h0000);
      peek("r2_side", 4'd2, 16'h2222);

      // Write beats completing load on the same register
      step();
      bus.ld_en = 1; bus.ld_addr = 3; step();
      idle(); bus.ld_data = 16'h4321;
      bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 16'h1234; step(); idle();
      peek("r3_collide", 4'd3, 16'h1234);

      // Call: window shift with wrap; window-directed aux is dropped, other writes proceed
      wr(4'd13, 16'h0001); wr(4'd14, 16'h0002); wr(4'd15, 16'hFFFE);
      bus.call_en = 1; bus.call_ofs = 16'h0005;
      bus.aux_en = 1; bus.aux_data = 16'hDEAD;
      bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 16'h0202; step(); idle();
      peek("call_r13", 4'd13, 16'h0002);
      peek("call_r14", 4'd14, 16'hFFFE);
      peek("call_r15", 4'd15, 16'h0003);
      step();
      peek("call_r2", 4'd2, 16'h0202);

      // Return, then aux beats ALU write to R13
      wr(4'd13, 16'h0007); wr(4'd14, 16'h0008);
      bus.ret_en = 1; bus.ret_data = 16'h0009; step(); idle();
      peek("ret_r14", 4'd14, 16'h0007);
      peek("ret_r15", 4'd15, 16'h0008);
      peek("ret_r13", 4'd13, 16'h0009);
      step();
      bus.aux_en = 1; bus.aux_data = 16'hAAAA;
      bus.wr_en = 1; bus.wr_addr = 13; bus.wr_data = 16'h5555; step(); idle();
      peek("aux_r13", 4'd13, 16'hAAAA);

      // Load completing into a window register during a call overrides the shift
      bus.ld_en = 1; bus.ld_addr = 14; step();
      idle(); bus.call_en = 1; bus.call_ofs = 16'h0001; bus.ld_data = 16'hBEEF; step(); idle();
      peek("winld_r13", 4'd13, 16'h0007);
      peek("winld_r14", 4'd14, 16'hBEEF);
      peek("winld_r15", 4'd15, 16'h0009);

      // Protocol errors
      step();
      bus.call_en = 1; bus.ret_en = 1; step(); idle(); #1;
      chk("err_callret", bus.err, 1'b1);
      peek("err_r13", 4'd13, 16'h0007);
      peek("err_r14", 4'd14, 16'hBEEF);
      step();
      chk("err_clear", bus.err, 1'b0);
      peek("err_r15", 4'd15, 16'h0009);
      step();
      bus.ld_en = 1; bus.ld_addr = 0; step(); idle(); #1;
      chk("err_ld0", bus.err, 1'b1);
      chk("ld0_flags", bus.ld_flags, 3'b000);
      step();
      chk("err_ld0_clear", bus.err, 1'b0);

      // Reset while a load is pending
      bus.ld_en = 1; bus.ld_addr = 9; step();
      idle(); bus.ld_data = 16'h9999;
      rst = 1'b0; #1;
      chk("rst_stall_mid", bus.stall, 1'b0);
      rst = 1'b1; #1;
      chk("rst_flags", bus.ld_flags, 3'b000);
      step(); idle();
      peek("rst_r9", 4'd9, 16'h0000);
      peek("rst_r13", 4'd13, 16'h0000);
      peek("rst_r5", 4'd5, 16'h0000);

      // 32x32, four read ports: window R29..R31
      wr2(5'd29, 32'h1111_1111); wr2(5'd30, 32'h2222_2222);
      wr2(5'd31, 32'hFFFF_FFF0); wr2(5'd7, 32'hDEAD_BEEF);
      bus2.call_en = 1; bus2.call_ofs = 32'h0000_0020; step(); idle2();
      bus2.rd_addr = {5'd7, 5'd31, 5'd30, 5'd29}; #1;
      chk("p32_rd0", bus2.rd_data[31:0],   32'h2222_2222);
      chk("p32_rd1", bus2.rd_data[63:32],  32'hFFFF_FFF0);
      chk("p32_rd2", bus2.rd_data[95:64],  32'h0000_0010);
      chk("p32_rd3", bus2.rd_data[127:96], 32'hDEAD_BEEF);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/hera_regf_mp.md
HERA_REGF_MP -- requirements
Module: hera_regf_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits (legal range 8..64).
REQ-002 SHALL have parameter NREG, default 16, register count (power of two, at least 8); AW = log2(NREG) is derived and not overridable.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (legal range 1..4).
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port rd_addr, input, NRD*AW, read addresses; port k occupies bits [k*AW +: AW].
REQ-007 SHALL have port rd_data, output, NRD*DATA_W, read data, packed in the same order as rd_addr.
REQ-008 SHALL have ports wr_en (input, 1), wr_addr (input, AW) and wr_data (input, DATA_W), the ALU write port.
REQ-009 SHALL have ports ld_en (input, 1) and ld_addr (input, AW), the deferred-load request.
REQ-010 SHALL have port ld_data, input, DATA_W, load data from memory, valid in the cycle after ld_en.
REQ-011 SHALL have ports aux_en (input, 1) and aux_data (input, DATA_W), the multiply high-word write to R[NREG-3].
REQ-012 SHALL have ports call_en (input, 1) and call_ofs (input, DATA_W), the call window shift and frame offset.
REQ-013 SHALL have ports ret_en (input, 1) and ret_data (input, DATA_W), the return window shift and the value restored to R[NREG-3].
REQ-014 SHALL have port ld_flags, output, 3, {pending, ld_data MSB, ld_data==0}; all bits are 0 when no load is pending.
REQ-015 SHALL have port stall, output, 1, read hazard on a pending load.
REQ-016 SHALL have port err, output, 1, registered one-cycle protocol error pulse.

Function
REQ-017 SHALL hardwire R0: reads return 0 and writes to address 0 are discarded.
REQ-018 SHALL provide combinational reads of the register array on every read port, subject to REQ-027.
REQ-019 SHALL write wr_data into R[wr_addr] at the rising edge when wr_en=1.
REQ-020 SHALL, on ld_en=1 in cycle N, capture ld_addr and set pending; in cycle N+1 it SHALL write ld_data into the captured register, and pending SHALL clear unless a new ld_en arrives in N+1.
REQ-021 SHALL sustain back-to-back loads: one load completes per cycle while a new request is captured.
REQ-022 SHALL give a wr_en write priority over a completing load when both target the same register in the same cycle; writes to different registers both take effect.
REQ-023 SHALL, on call_en=1 alone, perform R[NREG-3]<=R[NREG-2], R[NREG-2]<=R[NREG-1], R[NREG-1]<=R[NREG-1]+call_ofs, with the sum truncated to DATA_W bits.
REQ-024 SHALL, on ret_en=1 alone, perform R[NREG-2]<=R[NREG-3], R[NREG-1]<=R[NREG-2], R[NREG-3]<=ret_data.
REQ-025 SHALL, during a call or return: let a completing load to a window register override the shift for that register; ignore wr_en and aux_en writes to window registers; still perform writes to other registers.
REQ-026 SHALL, when aux_en=1 without call or return, write aux_data to R[NREG-3], with priority over wr_en and over a completing load to that register.
REQ-027 SHALL assert stall combinationally while pending=1 and any rd_addr equals the captured load address, except address 0.
REQ-028 SHALL pulse err for one cycle after a cycle with call_en=ret_en=1 (neither operation executes) or with ld_en=1 and ld_addr=0 (no pending is set).

Reset
REQ-029 SHALL, while rst=0, clear all registers, the pending flag and the captured load address to 0, and hold err=0 and stall=0.
REQ-030 SHALL cancel a pending load on reset: the ld_data of the following cycle is not written.

Configuration
REQ-031 SHALL, with macro HERA_REGF_BYPASS_EN defined, return ld_data on any read port matching the pending load address and hold stall at 0.
REQ-032 SHALL, without HERA_REGF_BYPASS_EN, return the stale array value on such reads and drive stall per REQ-027.

Verification
REQ-033 SHALL cover the load path: ld_en to R5 (ld_data=16'h8000 next cycle) with rd_addr0=5 in that cycle -> with bypass, rd_data0=8000 and stall=0; without bypass, stall=1; afterwards R5=8000 and ld_flags during pending = 3'b110.
REQ-034 SHALL cover a write/load collision: load to R3 completing with wr_en to R3 (data 1234) in the same cycle -> R3=1234.
REQ-035 SHALL cover the call window: R13=1, R14=2, R15=FFFE, call_ofs=5 -> R13=2, R14=FFFE, R15=0003 (wraps).
REQ-036 SHALL cover return and aux: R13=7, R14=8, ret_data=9 -> R14=7, R15=8, R13=9; then aux_en with aux_data=AAAA together with wr_en to R13 (data 5555) -> R13=AAAA.
REQ-037 SHALL cover errors and reset: call_en=ret_en=1 -> err pulses one cycle and window unchanged; ld_en to R0 -> err pulses and pending stays 0; rst asserted mid-load -> all registers 0 and the load discarded.
REQ-038 SHALL cover parameterisation: with NREG=32, DATA_W=32, NRD=4 -> window registers are R29..R31 and all four read ports return correct data.
